mc_control_fsm: RTL
===================

# mc_control_fsm

Multicycle MIPS controller: a Moore state machine plus ALU decoder that sequences each instruction through fetch, decode, execute, memory and writeback cycles. Sits directly upstream of the unified instruction/data `memory`: it drives memory `we` (`memwrite`) and selects the memory address source (`iord`, PC vs ALUOut). It also generates every datapath enable and mux select, from the opcode/funct held in the instruction register and the ALU `zero` flag.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces state to FETCH.
- `op`  in  6  instruction[31:26] from instruction register.
- `funct`  in  6  instruction[5:0] from instruction register.
- `zero`  in  1  ALU result == 0.
- `memwrite`  out  1  drives memory `we`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  instruction register load enable.
- `pcen`  out  1  PC load enable.
- `regwrite`  out  1  register file write enable.
- `regdst`  out  1  write register select: 0 = rt, 1 = rd.
- `memtoreg`  out  1  writeback select: 0 = ALUOut, 1 = memory data register.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = rs value.
- `alusrcb`  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  ALU operation code.
- `state`  out  4  current state, for debug.

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, RTYPEEX = 6.
  - RTYPEWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11, BNEEX = 12.
- Transitions from DECODE, by `op`:
  - lw 100011 / sw 101011 -> MEMADR.
  - R-type 000000 -> RTYPEEX.
  - beq 000100 -> BEQEX.
  - addi 001000 -> ADDIEX.
  - j 000010 -> JEX.
  - any other op -> FETCH (executes as a NOP).
- Other transitions:
  - FETCH -> DECODE.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - RTYPEEX -> RTYPEWB -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - BEQEX, JEX, BNEEX -> FETCH.
  - Unused encodings 13-15 -> FETCH.
- Moore outputs; any output not listed for a state is 0:
  - FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01, aluop=00.
  - DECODE: `alusrcb`=11, aluop=00.
  - MEMADR, ADDIEX: `alusrca`=1, `alusrcb`=10, aluop=00.
  - MEMRD: `iord`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - RTYPEEX: `alusrca`=1, aluop=10.
  - RTYPEWB: `regwrite`=1, `regdst`=1.
  - ADDIWB: `regwrite`=1.
  - BEQEX: `alusrca`=1, aluop=01, `pcsrc`=01, branch=1.
  - BNEEX: as BEQEX but branchne=1 instead of branch.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- `pcen` = pcwrite | (branch & zero) | (branchne & ~zero).
- ALU decoder (`alucontrol`):
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
  - aluop 11 -> 010.

## Timing
- State register updates on `posedge clk`; `reset` clears it asynchronously to FETCH.
- While `reset` is high, outputs carry FETCH values: `irwrite`=1, `pcen`=1, `alusrcb`=01, `alucontrol`=010, all other outputs 0.
- Reset asserted in any state returns the FSM to FETCH immediately, without completing the instruction. A MEMWR cycle cut by reset before its clock edge performs no write.
- Outputs are combinational from `state` only, except `pcen` (also depends on `zero`) and `alucontrol` (also depends on `funct`).
- `op` and `funct` are sampled only from DECODE onward; the instruction register is stable from then on.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3, unknown op 2.
- The memory write takes effect at the rising edge that ends MEMWR.

## Configuration
- `BNE_EN` defined: DECODE with op 000101 -> BNEEX; PC loads when `zero`=0.
- `BNE_EN` undefined: op 000101 is an unknown op (DECODE -> FETCH); BNEEX is unreachable and branchne is tied to 0.

## Test plan
- Reset asserted mid-RTYPEEX -> `state`=0 with no clock edge; `irwrite`=1, `pcen`=1, `memwrite`=0.
- lw (op 100011) -> states 0,1,2,3,4,0; `iord`=1 only in state 3; `regwrite`=1 with `memtoreg`=1 only in state 4.
- sw (op 101011) -> states 0,1,2,5,0; `memwrite`=1 for exactly one cycle (state 5) with `iord`=1.
- R-type with funct 100010 -> `alucontrol`=110 in RTYPEEX; funct 101010 -> 111; funct 111111 -> 010; RTYPEWB has `regdst`=1, `regwrite`=1.
- beq in BEQEX: `zero`=1 -> `pcen`=1, `pcsrc`=01; `zero`=0 -> `pcen`=0.
- op 000101: with `BNE_EN` defined -> BNEEX, `zero`=0 gives `pcen`=1; without `BNE_EN` -> DECODE -> FETCH (2 cycles), `pcen`=0 outside FETCH.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM + ALU decoder: Moore outputs from state (pcen/alucontrol also from zero/funct), 2-5 cycles per instruction.
// No backpressure; reset (async, active-high) returns to FETCH at once. Define BNE_EN to add the bne instruction.
module mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    state_t     state_q, state_d;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            // Single-cycle tails, writebacks and unused encodings all return to FETCH.
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        branch   = 1'b0;
        branchne = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            ADDIWB:  regwrite = 1'b1;
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef BNE_EN
            BNEEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                branchne = 1'b1;
            end
`endif
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero) | (branchne & ~zero);
    assign state = state_q;

endmodule
